spi_adc_host: RTL

//  Host-side SPI controller (mode 0) driving the spi_adc register slave from system logic.
//  - Accepts one register command per handshake and serialises a 16-bit frame MSB first.
//  - Frame format is {1'b0, wr, addr[1:0], data[ADC_WIDTH-1:0]}.
//  - Returns the 12 LSBs captured from miso.
//  - Used by on-chip sequencers and the system testbench in place of hand-timed SPI tasks.

---
 rtl/spi_adc_pkg.sv | 37 +++
 rtl/sync_2ff.sv | 25 ++
 rtl/spi_adc_host.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/spi_adc_pkg.sv
// Shared constants for the spi_adc register slave and its SPI host controller.
package spi_adc_pkg;

    // Register map
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DATA   = 2'd2;
    localparam logic [1:0] REG_INFO   = 2'd3;

    // CTRL register bit positions
    localparam int unsigned CTRL_ADC_EN  = 0;
    localparam int unsigned CTRL_START   = 1;
    localparam int unsigned CTRL_AUTO    = 2;
    localparam int unsigned CTRL_VREF    = 3;
    localparam int unsigned CTRL_INT_EN  = 4;
    localparam int unsigned CTRL_CLK_SEL = 6;

    // STATUS register bit positions
    localparam int unsigned STATUS_EOC  = 0;
    localparam int unsigned STATUS_BUSY = 1;

    // Frame opcode fields: {FRAME_START, wr, addr, data}
    localparam logic FRAME_START = 1'b0;
    localparam logic OP_WRITE    = 1'b1;
    localparam logic OP_READ     = 1'b0;

    // Host controller FSM
    typedef enum logic [2:0] {
        HOST_IDLE,
        HOST_SETUP,
        HOST_LO,
        HOST_HI,
        HOST_HOLD,
        HOST_GAP
    } host_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input bit.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Metastability filter: two back-to-back flops, cleared by reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/spi_adc_host.sv
// SPI mode-0 host: one register command per handshake, 16-bit frame MSB first,
// returns the low ADC_WIDTH bits shifted in from miso.
module spi_adc_host
    import spi_adc_pkg::*;
#(
    parameter int unsigned ADC_WIDTH = 12,
    parameter int unsigned SCK_HALF  = 10,
    parameter int unsigned CS_SETUP  = 5,
    parameter int unsigned CS_HOLD   = 5,
    parameter int unsigned CS_GAP    = 10
) (
    input  logic                 sys_clk,
    input  logic                 reset_,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [1:0]           cmd_addr,
    input  logic [ADC_WIDTH-1:0] cmd_wdata,
    output logic                 rsp_valid,
    output logic [ADC_WIDTH-1:0] rsp_rdata,
    output logic                 busy,
    output logic                 cs,
    output logic                 sck,
    output logic                 mosi,
    input  logic                 miso
);

    localparam int unsigned FW      = ADC_WIDTH + 4;
    localparam int unsigned MAX_A   = (SCK_HALF > CS_SETUP) ? SCK_HALF : CS_SETUP;
    localparam int unsigned MAX_B   = (CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP;
    localparam int unsigned CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned BW      = $clog2(FW);
    // The IDLE acceptance cycle is the last cs-high cycle, so GAP runs one short.
    localparam int unsigned GAP_LAST = (CS_GAP > 1) ? CS_GAP - 2 : 0;

    host_state_e          state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [FW-2:0]        tx_q, tx_d;
    // Only the data field is kept; header-period bits fall off the top.
    logic [ADC_WIDTH-1:0] rx_q, rx_d;
    logic                 cs_q, cs_d;
    logic                 sck_q, sck_d;
    logic                 mosi_q, mosi_d;
    logic                 cmd_ready_q, cmd_ready_d;
    logic                 busy_q, busy_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [ADC_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                 miso_s;
    logic [FW-1:0]        frame_c;

    sync_2ff u_miso_sync (
        .clk_i (sys_clk),
        .rst_i (reset_),
        .d_i   (miso),
        .q_o   (miso_s)
    );

    // Frame assembled from the command inputs; read frames carry a zero data field
    assign frame_c = {FRAME_START, cmd_write, cmd_addr,
                      cmd_write ? cmd_wdata : ADC_WIDTH'(0)};

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        cs_d        = cs_q;
        sck_d       = sck_q;
        mosi_d      = mosi_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;

        unique case (state_q)
            HOST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    tx_d    = frame_c[FW-2:0];
                    mosi_d  = frame_c[FW-1];
                    cs_d    = 1'b0;
                    bit_d   = BW'(FW - 1);
                    cnt_d   = '0;
                    state_d = HOST_SETUP;
                end
            end
            HOST_SETUP: begin
                if (cnt_q == CW'(CS_SETUP - 1)) begin
                    cnt_d   = '0;
                    state_d = HOST_LO;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HOST_LO: begin
                if (cnt_q == CW'(SCK_HALF - 1)) begin
                    cnt_d   = '0;
                    sck_d   = 1'b1;
                    state_d = HOST_HI;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HOST_HI: begin
                if (cnt_q == CW'(SCK_HALF - 1)) begin
                    cnt_d = '0;
                    sck_d = 1'b0;
                    rx_d  = {rx_q[ADC_WIDTH-2:0], miso_s};
                    if (bit_q == '0) begin
                        mosi_d  = 1'b0;
                        state_d = HOST_HOLD;
                    end else begin
                        bit_d   = bit_q - BW'(1);
                        mosi_d  = tx_q[FW-2];
                        tx_d    = {tx_q[FW-3:0], 1'b0};
                        state_d = HOST_LO;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HOST_HOLD: begin
                if (cnt_q == CW'(CS_HOLD - 1)) begin
                    cnt_d       = '0;
                    cs_d        = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = rx_q;
                    state_d     = HOST_GAP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HOST_GAP: begin
                if (cnt_q == CW'(GAP_LAST)) begin
                    cnt_d   = '0;
                    state_d = HOST_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = HOST_IDLE;
            end
        endcase

        cmd_ready_d = (state_d == HOST_IDLE);
        busy_d      = (state_d != HOST_IDLE);
    end

    // State and output registers; reset aborts any frame immediately
    always_ff @(posedge sys_clk or posedge reset_) begin
        if (reset_) begin
            state_q     <= HOST_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            cs_q        <= 1'b1;
            sck_q       <= 1'b0;
            mosi_q      <= 1'b0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            cs_q        <= cs_d;
            sck_q       <= sck_d;
            mosi_q      <= mosi_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign cs        = cs_q;
    assign sck       = sck_q;
    assign mosi      = mosi_q;

endmodule
